// File: rtl/biriscv_fetch_queue_pkg.sv
// Shared definitions for the compacting fetch queue: the stored entry record and its field layout.
package biriscv_fetch_queue_pkg;

    localparam int FQ_ENTRY_W      = 67;
    localparam int FQ_INSTR_LSB    = 0;
    localparam int FQ_PC_LSB       = 32;
    localparam int FQ_PRED_BIT     = 64;
    localparam int FQ_FFETCH_BIT   = 65;
    localparam int FQ_FPAGE_BIT    = 66;

    // Declared MSB-first so the packed layout matches the offsets above.
    typedef struct packed {
        logic        fault_page;
        logic        fault_fetch;
        logic        pred_taken;
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/biriscv_fetch_queue_compact.sv
// Combinational packet compactor: keeps slots first..last (last = first predicted-taken slot)
// and packs them to entry 0 upward; a faulting packet collapses to one marker entry.
module biriscv_fq_compact
    import biriscv_fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH   = 2,
    parameter int FETCH_WIDTH_W = 1,
    parameter int FIRST_W       = (FETCH_WIDTH_W > 0) ? FETCH_WIDTH_W : 1
) (
    input  logic [32*FETCH_WIDTH-1:0]           instr_i,
    input  logic [31:0]                         pc_i,
    input  logic [FIRST_W-1:0]                  first_i,
    input  logic [FETCH_WIDTH-1:0]              pred_branch_i,
    input  logic                                fault_fetch_i,
    input  logic                                fault_page_i,
    output fq_entry_t [FETCH_WIDTH-1:0]         entries_o,
    output logic [FETCH_WIDTH_W:0]              push_cnt_o
);

    int                          cnt;
    int                          slot;
    logic                        stop;
    logic [31:0]                 pc_base;
    logic [32*FETCH_WIDTH-1:0]   instr_sh;
    logic [FETCH_WIDTH-1:0]      pred_sh;

    always_comb begin
        entries_o = '0;
        cnt       = 0;
        slot      = 0;
        stop      = 1'b0;
        instr_sh  = '0;
        pred_sh   = '0;
        pc_base   = pc_i & ~32'((FETCH_WIDTH * 4) - 1);

        if (fault_fetch_i || fault_page_i) begin
            entries_o[0].pc          = pc_i;
            entries_o[0].fault_fetch = fault_fetch_i;
            entries_o[0].fault_page  = fault_page_i;
            cnt                      = 1;
        end else begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                slot = int'(first_i) + j;
                if (!stop && (slot < FETCH_WIDTH)) begin
                    instr_sh                = instr_i >> (32 * slot);
                    pred_sh                 = pred_branch_i >> slot;
                    entries_o[j].instr      = instr_sh[31:0];
                    entries_o[j].pc         = pc_base | (32'(slot) << 2);
                    entries_o[j].pred_taken = pred_sh[0];
                    cnt                     = cnt + 1;
                    stop                    = pred_sh[0];
                end
            end
        end

        push_cnt_o = (FETCH_WIDTH_W + 1)'(cnt);
    end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Compacting instruction queue between fetch and the multi-issue decoder: flop storage,
// circular pointers, in-order multi-lane pop, flush with priority over push/pop.
module biriscv_fetch_queue
    import biriscv_fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH   = 2,
    parameter int FETCH_WIDTH_W = 1,
    parameter int ISSUE_WIDTH   = 2,
    parameter int DEPTH         = 8,
    parameter int DEPTH_W       = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        fetch_in_valid_i,
    input  logic [32*FETCH_WIDTH-1:0]   fetch_in_instr_i,
    input  logic [31:0]                 fetch_in_pc_i,
    input  logic [FETCH_WIDTH-1:0]      fetch_in_pred_branch_i,
    input  logic                        fetch_in_fault_fetch_i,
    input  logic                        fetch_in_fault_page_i,
    output logic                        fetch_in_accept_o,
    output logic [ISSUE_WIDTH-1:0]      out_valid_o,
    output logic [32*ISSUE_WIDTH-1:0]   out_instr_o,
    output logic [32*ISSUE_WIDTH-1:0]   out_pc_o,
    output logic [ISSUE_WIDTH-1:0]      out_pred_taken_o,
    output logic [ISSUE_WIDTH-1:0]      out_fault_fetch_o,
    output logic [ISSUE_WIDTH-1:0]      out_fault_page_o,
    input  logic [ISSUE_WIDTH-1:0]      out_accept_i,
    output logic [DEPTH_W:0]            level_o
);

    localparam int FIRST_W = (FETCH_WIDTH_W > 0) ? FETCH_WIDTH_W : 1;

    fq_entry_t                  mem_q [DEPTH];
    fq_entry_t                  mem_d [DEPTH];
    logic [DEPTH_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]           count_q,  count_d;

    fq_entry_t [FETCH_WIDTH-1:0] cmp_entries;
    logic [FETCH_WIDTH_W:0]      cmp_cnt;
    logic [FIRST_W-1:0]          first;
    logic                        push;
    int                          pushed;
    int                          pops;
    logic                        blocked;

    assign first = FIRST_W'((fetch_in_pc_i >> 2) & 32'(FETCH_WIDTH - 1));

    biriscv_fq_compact #(
        .FETCH_WIDTH   (FETCH_WIDTH),
        .FETCH_WIDTH_W (FETCH_WIDTH_W),
        .FIRST_W       (FIRST_W)
    ) u_compact (
        .instr_i       (fetch_in_instr_i),
        .pc_i          (fetch_in_pc_i),
        .first_i       (first),
        .pred_branch_i (fetch_in_pred_branch_i),
        .fault_fetch_i (fetch_in_fault_fetch_i),
        .fault_page_i  (fetch_in_fault_page_i),
        .entries_o     (cmp_entries),
        .push_cnt_o    (cmp_cnt)
    );

    // Space check uses registered count only, so accept never depends on this cycle's inputs.
    assign fetch_in_accept_o = rst_i && ((DEPTH - int'(count_q)) >= FETCH_WIDTH);
    assign level_o           = count_q;

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        fq_entry_t lane_e;
        assign lane_e                    = mem_q[rd_ptr_q + DEPTH_W'(i)];
        assign out_valid_o[i]            = (int'(count_q) > i);
        assign out_instr_o[32*i +: 32]   = lane_e.instr;
        assign out_pc_o[32*i +: 32]      = lane_e.pc;
        assign out_pred_taken_o[i]       = lane_e.pred_taken;
        assign out_fault_fetch_o[i]      = lane_e.fault_fetch;
        assign out_fault_page_o[i]       = lane_e.fault_page;
    end

    always_comb begin
        push    = fetch_in_valid_i && fetch_in_accept_o;
        pushed  = push ? int'(cmp_cnt) : 0;

        // Only the leading run of accepted lanes pops, keeping issue in order.
        pops    = 0;
        blocked = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!blocked && out_valid_o[i] && out_accept_i[i]) begin
                pops = pops + 1;
            end else begin
                blocked = 1'b1;
            end
        end

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pops);
        wr_ptr_d = wr_ptr_q + DEPTH_W'(pushed);
        count_d  = (DEPTH_W + 1)'(int'(count_q) + pushed - pops);

        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (push && (j < int'(cmp_cnt))) begin
                mem_d[wr_ptr_q + DEPTH_W'(j)] = cmp_entries[j];
            end
        end

        if (flush_i) begin
            mem_d    = mem_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Directed self-checking bench for biriscv_fetch_queue at FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8.
module tb_biriscv_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        fetch_in_valid_i;
    logic [63:0] fetch_in_instr_i;
    logic [31:0] fetch_in_pc_i;
    logic [1:0]  fetch_in_pred_branch_i;
    logic        fetch_in_fault_fetch_i;
    logic        fetch_in_fault_page_i;
    logic        fetch_in_accept_o;
    logic [1:0]  out_valid_o;
    logic [63:0] out_instr_o;
    logic [63:0] out_pc_o;
    logic [1:0]  out_pred_taken_o;
    logic [1:0]  out_fault_fetch_o;
    logic [1:0]  out_fault_page_o;
    logic [1:0]  out_accept_i;
    logic [3:0]  level_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    biriscv_fetch_queue #(
        .FETCH_WIDTH   (2),
        .FETCH_WIDTH_W (1),
        .ISSUE_WIDTH   (2),
        .DEPTH         (8),
        .DEPTH_W       (3)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .flush_i                (flush_i),
        .fetch_in_valid_i       (fetch_in_valid_i),
        .fetch_in_instr_i       (fetch_in_instr_i),
        .fetch_in_pc_i          (fetch_in_pc_i),
        .fetch_in_pred_branch_i (fetch_in_pred_branch_i),
        .fetch_in_fault_fetch_i (fetch_in_fault_fetch_i),
        .fetch_in_fault_page_i  (fetch_in_fault_page_i),
        .fetch_in_accept_o      (fetch_in_accept_o),
        .out_valid_o            (out_valid_o),
        .out_instr_o            (out_instr_o),
        .out_pc_o               (out_pc_o),
        .out_pred_taken_o       (out_pred_taken_o),
        .out_fault_fetch_o      (out_fault_fetch_o),
        .out_fault_page_o       (out_fault_page_o),
        .out_accept_i           (out_accept_i),
        .level_o                (level_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_pkt(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [1:0] pred);
        fetch_in_valid_i       = 1'b1;
        fetch_in_pc_i          = pc;
        fetch_in_instr_i       = {i1, i0};
        fetch_in_pred_branch_i = pred;
        step();
        fetch_in_valid_i       = 1'b0;
        fetch_in_pred_branch_i = 2'b00;
    endtask

    task automatic pop(input logic [1:0] acc);
        out_accept_i = acc;
        step();
        out_accept_i = 2'b00;
    endtask

    initial begin
        rst_i                  = 1'b0;
        flush_i                = 1'b0;
        fetch_in_valid_i       = 1'b0;
        fetch_in_instr_i       = '0;
        fetch_in_pc_i          = '0;
        fetch_in_pred_branch_i = '0;
        fetch_in_fault_fetch_i = 1'b0;
        fetch_in_fault_page_i  = 1'b0;
        out_accept_i           = 2'b00;

        repeat (3) step();
        chk("rst_level", level_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_accept", fetch_in_accept_o, 0);
        rst_i = 1'b1;
        #1;
        chk("idle_accept", fetch_in_accept_o, 1);

        // Aligned full packet
        push_pkt(32'h8000_0000, 32'h0010_0093, 32'h0020_0113, 2'b00);
        chk("t1_valid", out_valid_o, 2'b11);
        chk("t1_pc0", out_pc_o[31:0], 32'h8000_0000);
        chk("t1_pc1", out_pc_o[63:32], 32'h8000_0004);
        chk("t1_instr0", out_instr_o[31:0], 32'h0010_0093);
        chk("t1_instr1", out_instr_o[63:32], 32'h0020_0113);
        chk("t1_level", level_o, 2);
        pop(2'b11);
        chk("t1_drain", level_o, 0);

        // Misaligned packet drops slot 0
        push_pkt(32'h8000_0004, 32'hAAAA_0001, 32'hBBBB_0002, 2'b00);
        chk("t2_valid", out_valid_o, 2'b01);
        chk("t2_pc0", out_pc_o[31:0], 32'h8000_0004);
        chk("t2_instr0", out_instr_o[31:0], 32'hBBBB_0002);
        chk("t2_level", level_o, 1);
        pop(2'b01);
        chk("t2_drain", level_o, 0);

        // Predicted-taken slot 0 truncates the packet
        push_pkt(32'h8000_0008, 32'hCCCC_0003, 32'hDDDD_0004, 2'b01);
        chk("t3_level", level_o, 1);
        chk("t3_pred0", out_pred_taken_o[0], 1);
        chk("t3_pc0", out_pc_o[31:0], 32'h8000_0008);
        chk("t3_valid", out_valid_o, 2'b01);
        pop(2'b01);

        // Fill to capacity across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            chk("t4_accept_pre", fetch_in_accept_o, 1);
            push_pkt(32'h0000_0100 + 32'(k * 8), 32'h1000 + 32'(k * 2), 32'h1001 + 32'(k * 2), 2'b00);
        end
        chk("t4_full_level", level_o, 8);
        chk("t4_full_accept", fetch_in_accept_o, 0);
        chk("t4_full_pc1", out_pc_o[63:32], 32'h0000_0104);
        pop(2'b11);
        chk("t4_pop_level", level_o, 6);
        chk("t4_pop_accept", fetch_in_accept_o, 1);
        chk("t4_pop_pc0", out_pc_o[31:0], 32'h0000_0108);
        chk("t4_pop_instr0", out_instr_o[31:0], 32'h1002);

        // Out-of-order lane accept is ignored
        pop(2'b11);
        pop(2'b01);
        chk("t5_level3", level_o, 3);
        chk("t5_pc0_pre", out_pc_o[31:0], 32'h0000_0114);
        pop(2'b10);
        chk("t5_hold_level", level_o, 3);
        chk("t5_hold_pc0", out_pc_o[31:0], 32'h0000_0114);

        // Flush beats a same-cycle packet
        push_pkt(32'h0000_0200, 32'h2000, 32'h2001, 2'b00);
        chk("t6_level5", level_o, 5);
        flush_i                = 1'b1;
        push_pkt(32'h0000_0300, 32'h3000, 32'h3001, 2'b00);
        flush_i                = 1'b0;
        chk("t6_flush_level", level_o, 0);
        chk("t6_flush_valid", out_valid_o, 0);

        // Page-faulting packet becomes a single marker entry
        fetch_in_fault_page_i = 1'b1;
        push_pkt(32'h8000_0010, 32'hDEAD_BEEF, 32'hFEED_F00D, 2'b00);
        fetch_in_fault_page_i = 1'b0;
        chk("t6_fault_level", level_o, 1);
        chk("t6_fault_instr", out_instr_o[31:0], 0);
        chk("t6_fault_page", out_fault_page_o[0], 1);
        chk("t6_fault_fetch", out_fault_fetch_o[0], 0);
        chk("t6_fault_pc", out_pc_o[31:0], 32'h8000_0010);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Mid-operation reset discards contents
        push_pkt(32'h0000_0400, 32'h4000, 32'h4001, 2'b00);
        push_pkt(32'h0000_0408, 32'h4002, 32'h4003, 2'b00);
        chk("t6_level4", level_o, 4);
        rst_i = 1'b0;
        step();
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_valid", out_valid_o, 0);
        rst_i = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
